// File: rtl/spi_reg_sequencer.sv
// Register command front end for an 8-bit SPI byte engine: address byte then data byte under one cs_n.
// Optional transfer watchdog enabled by defining SPI_SEQ_TIMEOUT_EN (adds parameter TIMEOUT).
module spi_reg_sequencer #(
    parameter int unsigned CS_SETUP = 4,
    parameter int unsigned CS_HOLD  = 4,
    parameter int unsigned GAP      = 2
`ifdef SPI_SEQ_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT  = 1023
`endif
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic [7:0] spi_data_in,
    output logic       spi_start,
    input  logic       spi_busy,
    input  logic [7:0] spi_data_out,
    output logic       cs_n
);

    localparam int unsigned CNT_W      = 10;
    localparam int unsigned SETUP_LAST = (CS_SETUP == 0) ? 0 : CS_SETUP - 1;
    localparam int unsigned HOLD_LAST  = (CS_HOLD == 0) ? 0 : CS_HOLD - 1;
    localparam int unsigned GAP_LAST   = (GAP == 0) ? 0 : GAP - 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SETUP,
        S_A_START,
        S_A_WHI,
        S_A_WLO,
        S_GAPW,
        S_D_START,
        S_D_WHI,
        S_D_WLO,
        S_HOLD
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_rw;
    logic [6:0]         r_addr;
    logic [7:0]         r_wdata;
    logic               r_cs_n;
    logic               w_cs_n_nxt;
    logic               r_spi_start;
    logic               w_spi_start_nxt;
    logic [7:0]         r_spi_data_in;
    logic [7:0]         w_spi_data_in_nxt;
    logic               r_cmd_ready;
    logic               w_cmd_ready_nxt;
    logic               r_rsp_valid;
    logic               w_rsp_valid_nxt;
    logic [7:0]         r_rsp_rdata;
    logic [7:0]         w_rsp_rdata_nxt;
    logic               w_accept;
`ifdef SPI_SEQ_TIMEOUT_EN
    logic [CNT_W-1:0]   r_wdog;
    logic [CNT_W-1:0]   w_wdog_nxt;
    logic               r_rsp_err;
    logic               w_rsp_err_nxt;
    logic               w_wait;
`endif

    assign w_accept = cmd_valid & r_cmd_ready;

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt + CNT_W'(1);
        w_cs_n_nxt        = r_cs_n;
        w_spi_data_in_nxt = r_spi_data_in;
        w_rsp_valid_nxt   = 1'b0;
        w_rsp_rdata_nxt   = r_rsp_rdata;
`ifdef SPI_SEQ_TIMEOUT_EN
        w_rsp_err_nxt     = r_rsp_err;
        w_wait            = 1'b0;
        w_wdog_nxt        = '0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_SETUP;
                    w_cnt_nxt   = '0;
                    w_cs_n_nxt  = 1'b0;
`ifdef SPI_SEQ_TIMEOUT_EN
                    w_rsp_err_nxt = 1'b0;
`endif
                end
            end
            S_SETUP: begin
                if (r_cnt == CNT_W'(SETUP_LAST)) begin
                    w_state_nxt       = S_A_START;
                    w_spi_data_in_nxt = {r_rw, r_addr};
                end
            end
            S_A_START: w_state_nxt = S_A_WHI;
            S_A_WHI: begin
                if (spi_busy) w_state_nxt = S_A_WLO;
            end
            S_A_WLO: begin
                if (!spi_busy) begin
                    if (GAP == 0) begin
                        w_state_nxt       = S_D_START;
                        w_spi_data_in_nxt = r_rw ? 8'h00 : r_wdata;
                    end else begin
                        w_state_nxt = S_GAPW;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            S_GAPW: begin
                if (r_cnt == CNT_W'(GAP_LAST)) begin
                    w_state_nxt       = S_D_START;
                    w_spi_data_in_nxt = r_rw ? 8'h00 : r_wdata;
                end
            end
            S_D_START: w_state_nxt = S_D_WHI;
            S_D_WHI: begin
                if (spi_busy) w_state_nxt = S_D_WLO;
            end
            S_D_WLO: begin
                // Engine result is only valid in the first cycle busy reads low
                if (!spi_busy) begin
                    w_state_nxt     = S_HOLD;
                    w_cnt_nxt       = '0;
                    w_rsp_rdata_nxt = spi_data_out;
                end
            end
            S_HOLD: begin
                if (r_cnt == CNT_W'(HOLD_LAST)) begin
                    w_state_nxt     = S_IDLE;
                    w_cs_n_nxt      = 1'b1;
                    w_rsp_valid_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cs_n_nxt  = 1'b1;
            end
        endcase
`ifdef SPI_SEQ_TIMEOUT_EN
        // A stalled engine wait abandons the transfer but still closes cs_n through HOLD
        w_wait = (r_state == S_A_WHI) || (r_state == S_A_WLO) ||
                 (r_state == S_D_WHI) || (r_state == S_D_WLO);
        if (w_wait && (w_state_nxt == r_state) && (r_wdog >= CNT_W'(TIMEOUT))) begin
            w_state_nxt     = S_HOLD;
            w_cnt_nxt       = '0;
            w_rsp_err_nxt   = 1'b1;
            w_rsp_rdata_nxt = 8'h00;
        end
        w_wdog_nxt = (w_state_nxt != r_state) ? '0 : r_wdog + CNT_W'(1);
`endif
        w_spi_start_nxt = (w_state_nxt == S_A_START) || (w_state_nxt == S_D_START);
        w_cmd_ready_nxt = (w_state_nxt == S_IDLE) && (r_state == S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_rw          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_cs_n        <= 1'b1;
            r_spi_start   <= 1'b0;
            r_spi_data_in <= '0;
            r_cmd_ready   <= 1'b1;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_cs_n        <= w_cs_n_nxt;
            r_spi_start   <= w_spi_start_nxt;
            r_spi_data_in <= w_spi_data_in_nxt;
            r_cmd_ready   <= w_cmd_ready_nxt;
            r_rsp_valid   <= w_rsp_valid_nxt;
            r_rsp_rdata   <= w_rsp_rdata_nxt;
            if (w_accept) begin
                r_rw    <= cmd_rw;
                r_addr  <= cmd_addr;
                r_wdata <= cmd_wdata;
            end
        end
    end

`ifdef SPI_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wdog    <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            r_wdog    <= w_wdog_nxt;
            r_rsp_err <= w_rsp_err_nxt;
        end
    end

    assign rsp_err = r_rsp_err;
`else
    assign rsp_err = 1'b0;
`endif

    assign cmd_ready   = r_cmd_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign spi_data_in = r_spi_data_in;
    assign spi_start   = r_spi_start;
    assign cs_n        = r_cs_n;

endmodule

// File: tb/tb_spi_reg_sequencer.sv
// Scoreboard bench for spi_reg_sequencer with a behavioural SPI byte engine.
// Honours SPI_SEQ_TIMEOUT_EN (DUT built with TIMEOUT=20) for the stalled-engine case.
module tb_spi_reg_sequencer;

    localparam int unsigned CS_SETUP = 4;
    localparam int unsigned CS_HOLD  = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_rw;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic [7:0] spi_data_in;
    logic       spi_start;
    logic       spi_busy;
    logic [7:0] spi_data_out;
    logic       cs_n;

    int n_checks = 0;
    int n_fails  = 0;
    int n_start  = 0;
    int n_rsp    = 0;
    int n_accept = 0;
    int cs_low_cnt = 0;
    int low_after_busy = 0;
    int cs_hi_cnt = 0;
    int last_hi = 0;
    int eng_cyc = 3;
    bit eng_dead = 1'b0;

    logic [7:0] exp_byte_q[$];
    logic [7:0] miso_q[$];
    logic [8:0] exp_rsp_q[$];

`ifdef SPI_SEQ_TIMEOUT_EN
    spi_reg_sequencer #(.TIMEOUT(20)) u_dut (
`else
    spi_reg_sequencer u_dut (
`endif
        .clk          (clk),
        .reset_n      (reset_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_rw       (cmd_rw),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .spi_data_in  (spi_data_in),
        .spi_start    (spi_start),
        .spi_busy     (spi_busy),
        .spi_data_out (spi_data_out),
        .cs_n         (cs_n)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic rw, input logic [6:0] addr, input logic [7:0] wd,
                            input logic [7:0] miso, input bit with_rsp);
        exp_byte_q.push_back({rw, addr});
        exp_byte_q.push_back(rw ? 8'h00 : wd);
        miso_q.push_back(8'h5A);
        miso_q.push_back(miso);
        if (with_rsp) exp_rsp_q.push_back({1'b0, miso});
    endtask

    task automatic wait_accept();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            if (cmd_ready) got = 1'b1;
            step();
        end
        check_eq("accept_seen", 32'(got), 32'd1);
        check_eq("ready_drop", 32'(cmd_ready), 32'd0);
    endtask

    task automatic issue(input logic rw, input logic [6:0] addr, input logic [7:0] wd);
        cmd_valid = 1'b1;
        cmd_rw    = rw;
        cmd_addr  = addr;
        cmd_wdata = wd;
        wait_accept();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target, input int budget);
        for (int i = 0; i < budget && n_rsp < target; i++) step();
        check_eq("rsp_seen", 32'(n_rsp >= target), 32'd1);
    endtask

    // Byte engine: busy rises right after start, result valid only in the first busy-low cycle
    initial begin
        spi_busy     = 1'b0;
        spi_data_out = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (spi_start === 1'b1 && !eng_dead) begin
                spi_busy = 1'b1;
                repeat (eng_cyc) begin
                    @(posedge clk);
                    #1;
                end
                spi_busy     = 1'b0;
                spi_data_out = (miso_q.size() != 0) ? miso_q.pop_front() : 8'h00;
                @(posedge clk);
                #1;
                spi_data_out = 8'h00;
            end
        end
    end

    // Output monitor and scoreboard
    initial begin
        int byte_idx;
        logic prev_ready;
        logic [7:0] eb;
        logic [8:0] er;
        byte_idx   = 0;
        prev_ready = 1'b1;
        forever begin
            @(negedge clk);
            cs_low_cnt = cs_n ? 0 : cs_low_cnt + 1;
            if (spi_busy) low_after_busy = 0;
            else if (!cs_n) low_after_busy++;
            if (cs_n) cs_hi_cnt++;
            else begin
                if (cs_hi_cnt != 0) last_hi = cs_hi_cnt;
                cs_hi_cnt = 0;
            end
            if (prev_ready && !cmd_ready) n_accept++;
            prev_ready = cmd_ready;
            if (!reset_n) begin
                byte_idx = 0;
            end else begin
                if (spi_start) begin
                    n_start++;
                    check_eq("spi_byte_expected", 32'(exp_byte_q.size() != 0), 32'd1);
                    if (exp_byte_q.size() != 0) begin
                        eb = exp_byte_q.pop_front();
                        check_eq("spi_data_in", 32'(spi_data_in), 32'(eb));
                    end
                    if (byte_idx == 0) check_eq("cs_setup", 32'(cs_low_cnt), 32'(CS_SETUP + 1));
                    byte_idx++;
                end
                if (rsp_valid) begin
                    n_rsp++;
                    byte_idx = 0;
                    check_eq("cs_n_at_rsp", 32'(cs_n), 32'd1);
                    check_eq("rsp_expected", 32'(exp_rsp_q.size() != 0), 32'd1);
                    if (exp_rsp_q.size() != 0) begin
                        er = exp_rsp_q.pop_front();
                        check_eq("rsp_rdata", 32'(rsp_rdata), 32'(er[7:0]));
                        check_eq("rsp_err", 32'(rsp_err), 32'(er[8]));
                        if (!er[8]) check_eq("cs_hold", 32'(low_after_busy), 32'(CS_HOLD + 1));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running exp=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int base_rsp;
        int base_start;
        int base_acc;
        logic       r_rw;
        logic [6:0] r_addr;
        logic [7:0] r_wd;
        logic [7:0] r_miso;

        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_rw    = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        step();
        step();
        check_eq("rst_cs_n", 32'(cs_n), 32'd1);
        check_eq("rst_spi_start", 32'(spi_start), 32'd0);
        check_eq("rst_spi_data_in", 32'(spi_data_in), 32'd0);
        check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check_eq("rst_rsp_err", 32'(rsp_err), 32'd0);
        reset_n = 1'b1;
        step();
        step();

        // Write 0x2D <= 0x08
        base_rsp = n_rsp;
        push_cmd(1'b0, 7'h2D, 8'h08, 8'h3C, 1'b1);
        issue(1'b0, 7'h2D, 8'h08);
        wait_rsp(base_rsp + 1, 300);
        repeat (3) step();
        check_eq("t1_rsp_once", 32'(n_rsp - base_rsp), 32'd1);

        // Read 0x00 returning 0xE5; rdata must hold after engine output clears
        base_rsp = n_rsp;
        push_cmd(1'b1, 7'h00, 8'hAA, 8'hE5, 1'b1);
        issue(1'b1, 7'h00, 8'hAA);
        wait_rsp(base_rsp + 1, 300);
        step();
        check_eq("t2_valid_pulse", 32'(rsp_valid), 32'd0);
        check_eq("t2_rdata_hold", 32'(rsp_rdata), 32'hE5);

        // Back-to-back with cmd_valid held high
        eng_cyc    = 2;
        base_rsp   = n_rsp;
        base_start = n_start;
        base_acc   = n_accept;
        push_cmd(1'b0, 7'h11, 8'hC3, 8'h71, 1'b1);
        push_cmd(1'b1, 7'h12, 8'h00, 8'h72, 1'b1);
        cmd_valid = 1'b1;
        cmd_rw    = 1'b0;
        cmd_addr  = 7'h11;
        cmd_wdata = 8'hC3;
        wait_accept();
        cmd_rw    = 1'b1;
        cmd_addr  = 7'h12;
        cmd_wdata = 8'h00;
        wait_accept();
        cmd_valid = 1'b0;
        wait_rsp(base_rsp + 2, 400);
        repeat (3) step();
        check_eq("t3_starts", 32'(n_start - base_start), 32'd4);
        check_eq("t3_accepts", 32'(n_accept - base_acc), 32'd2);
        check_eq("t3_cs_gap", 32'(last_hi), 32'd2);

        // Random commands
        for (int k = 0; k < 4; k++) begin
            eng_cyc  = int'($urandom_range(2, 5));
            r_rw     = 1'($urandom_range(0, 1));
            r_addr   = 7'($urandom);
            r_wd     = 8'($urandom);
            r_miso   = 8'($urandom);
            base_rsp = n_rsp;
            push_cmd(r_rw, r_addr, r_wd, r_miso, 1'b1);
            issue(r_rw, r_addr, r_wd);
            wait_rsp(base_rsp + 1, 300);
        end

        // Reset while waiting on the data byte
        eng_cyc    = 6;
        base_rsp   = n_rsp;
        base_start = n_start;
        push_cmd(1'b0, 7'h33, 8'h99, 8'h44, 1'b0);
        issue(1'b0, 7'h33, 8'h99);
        for (int i = 0; i < 200 && n_start < base_start + 2; i++) step();
        check_eq("t4_reach_data", 32'(n_start - base_start), 32'd2);
        step();
        step();
        reset_n = 1'b0;
        #1;
        check_eq("t4_cs_n", 32'(cs_n), 32'd1);
        check_eq("t4_spi_start", 32'(spi_start), 32'd0);
        check_eq("t4_cmd_ready", 32'(cmd_ready), 32'd1);
        step();
        step();
        reset_n = 1'b1;
        repeat (10) step();
        check_eq("t4_no_rsp", 32'(n_rsp - base_rsp), 32'd0);
        eng_cyc  = 3;
        base_rsp = n_rsp;
        push_cmd(1'b1, 7'h34, 8'h00, 8'h9E, 1'b1);
        issue(1'b1, 7'h34, 8'h00);
        wait_rsp(base_rsp + 1, 300);

        // Engine that never raises busy
        eng_dead   = 1'b1;
        base_rsp   = n_rsp;
        base_start = n_start;
        exp_byte_q.push_back(8'h85);
`ifdef SPI_SEQ_TIMEOUT_EN
        exp_rsp_q.push_back({1'b1, 8'h00});
        issue(1'b1, 7'h05, 8'h00);
        wait_rsp(base_rsp + 1, 200);
        check_eq("t5_starts", 32'(n_start - base_start), 32'd1);
`else
        issue(1'b1, 7'h05, 8'h00);
        repeat (60) step();
        check_eq("t5_starts", 32'(n_start - base_start), 32'd1);
        check_eq("t5_stuck_ready", 32'(cmd_ready), 32'd0);
        check_eq("t5_stuck_cs_n", 32'(cs_n), 32'd0);
        check_eq("t5_no_rsp", 32'(n_rsp - base_rsp), 32'd0);
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
`endif
        eng_dead = 1'b0;
        base_rsp = n_rsp;
        push_cmd(1'b0, 7'h7F, 8'h01, 8'hC9, 1'b1);
        issue(1'b0, 7'h7F, 8'h01);
        wait_rsp(base_rsp + 1, 300);
        repeat (3) step();

        check_eq("left_bytes", 32'(exp_byte_q.size()), 32'd0);
        check_eq("left_rsp", 32'(exp_rsp_q.size()), 32'd0);
        check_eq("left_miso", 32'(miso_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
